// File: rtl/player_data_tx_if.sv
// Sync-link transmit port: parallel state word in, 8N1 serial line and status out.
interface player_data_tx_if #(
    parameter int DATA_WIDTH = 48
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic                  tx_out;
    logic                  busy_out;
    logic                  packet_done_out;

    modport master (
        output data_in,
        output data_in_valid,
        input  tx_out,
        input  busy_out,
        input  packet_done_out
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output tx_out,
        output busy_out,
        output packet_done_out
    );
endinterface

// File: rtl/player_data_tx.sv
// Frames the player state word as [header, payload MSB-first, optional checksum] and sends it as UART 8N1.
// Define SYNC_TX_CHECKSUM_EN to append the XOR-of-payload checksum byte.
//
// state    | meaning
// ST_IDLE  | line high, waiting for a word strobe
// ST_START | driving the start bit (0)
// ST_DATA  | driving the 8 data bits, LSB first
// ST_STOP  | driving the stop bit (1); chooses next byte, next packet or idle
module player_data_tx #(
    parameter int         DATA_WIDTH   = 48,
    parameter int         CLKS_PER_BIT = 644,
    parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
    input  logic            clk_pixel_in,
    input  logic            rst_n_in,
    player_data_tx_if.slave bus
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(NB + 2);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
`ifdef SYNC_TX_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB + 1);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB);
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [2:0]            r_bit_idx;
    logic [IDX_W-1:0]      r_byte_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [7:0]            r_byte;
    logic [DATA_WIDTH-1:0] r_pend;
    logic                  r_pend_valid;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_armed;
`ifdef SYNC_TX_CHECKSUM_EN
    logic [7:0]            r_csum;
    logic [7:0]            w_csum_nxt;
`endif

    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [2:0]            w_bit_nxt;
    logic [2:0]            w_bit_inc;
    logic [IDX_W-1:0]      w_byte_idx_nxt;
    logic [IDX_W-1:0]      w_idx_inc;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [7:0]            w_byte_nxt;
    logic [DATA_WIDTH-1:0] w_pend_nxt;
    logic                  w_pend_valid_nxt;
    logic                  w_tx_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_tc;
    logic                  w_last;
    logic                  w_complete;
    logic                  w_strobe;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_word;

    // Strobes arriving on the first clock after reset release are dropped.
    assign w_strobe   = bus.data_in_valid & r_armed;
    assign w_tc       = (r_cnt == '0);
    assign w_last     = (r_byte_idx == LAST_IDX);
    assign w_complete = (r_state == ST_STOP) && w_tc && w_last;
    assign w_bit_inc  = r_bit_idx + 3'd1;
    assign w_idx_inc  = r_byte_idx + IDX_ONE;

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
            r_shift      <= '0;
            r_byte       <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_armed      <= 1'b0;
`ifdef SYNC_TX_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_idx    <= w_bit_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_byte       <= w_byte_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_tx         <= w_tx_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_armed      <= 1'b1;
`ifdef SYNC_TX_CHECKSUM_EN
            r_csum       <= w_csum_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_bit_nxt        = r_bit_idx;
        w_byte_idx_nxt   = r_byte_idx;
        w_shift_nxt      = r_shift;
        w_byte_nxt       = r_byte;
        w_pend_nxt       = r_pend;
        w_pend_valid_nxt = r_pend_valid;
        w_tx_nxt         = r_tx;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_load           = 1'b0;
        w_load_word      = bus.data_in;
`ifdef SYNC_TX_CHECKSUM_EN
        w_csum_nxt       = r_csum;
`endif

        if (r_state != ST_IDLE) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
        end

        // On the completion cycle a strobe becomes the next packet, not the pending word.
        if (w_strobe && (r_state != ST_IDLE) && !w_complete) begin
            w_pend_nxt       = bus.data_in;
            w_pend_valid_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (w_strobe) begin
                    w_load = 1'b1;
                end
            end
            ST_START: begin
                if (w_tc) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = CNT_LOAD;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_byte[0];
                end
            end
            ST_DATA: begin
                if (w_tc) begin
                    w_cnt_nxt = CNT_LOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt = w_bit_inc;
                        w_tx_nxt  = r_byte[w_bit_inc];
                    end
                end
            end
            ST_STOP: begin
                if (w_last && (r_cnt == CNT_ONE)) begin
                    w_done_nxt = 1'b1;
                end
                if (w_tc && w_last) begin
                    if (w_strobe) begin
                        w_load           = 1'b1;
                        w_pend_valid_nxt = 1'b0;
                    end else if (r_pend_valid) begin
                        w_load           = 1'b1;
                        w_load_word      = r_pend;
                        w_pend_valid_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_tx_nxt    = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end
                end else if (w_tc) begin
                    w_state_nxt    = ST_START;
                    w_cnt_nxt      = CNT_LOAD;
                    w_byte_idx_nxt = w_idx_inc;
                    w_tx_nxt       = 1'b0;
`ifdef SYNC_TX_CHECKSUM_EN
                    if (w_idx_inc == LAST_IDX) begin
                        w_byte_nxt = r_csum;
                    end else begin
                        w_byte_nxt  = r_shift[DATA_WIDTH-1 -: 8];
                        w_shift_nxt = r_shift << 8;
                        w_csum_nxt  = r_csum ^ r_shift[DATA_WIDTH-1 -: 8];
                    end
`else
                    w_byte_nxt  = r_shift[DATA_WIDTH-1 -: 8];
                    w_shift_nxt = r_shift << 8;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_state_nxt    = ST_START;
            w_cnt_nxt      = CNT_LOAD;
            w_bit_nxt      = '0;
            w_byte_idx_nxt = '0;
            w_shift_nxt    = w_load_word;
            w_byte_nxt     = HEADER_BYTE;
            w_tx_nxt       = 1'b0;
            w_busy_nxt     = 1'b1;
`ifdef SYNC_TX_CHECKSUM_EN
            w_csum_nxt     = '0;
`endif
        end
    end

    assign bus.tx_out          = r_tx;
    assign bus.busy_out        = r_busy;
    assign bus.packet_done_out = r_done;

endmodule

// File: tb/tb_player_data_tx.sv
// Bench for player_data_tx: UART line decoder feeding a byte scoreboard, plus timing checks.
module tb_player_data_tx;
    localparam int DW  = 16;
    localparam int CPB = 4;
    localparam int NB  = DW / 8;
`ifdef SYNC_TX_CHECKSUM_EN
    localparam bit CSUM_EN   = 1'b1;
    localparam int PKT_BYTES = NB + 2;
`else
    localparam bit CSUM_EN   = 1'b0;
    localparam int PKT_BYTES = NB + 1;
`endif
    localparam int PKT_CYC = PKT_BYTES * 10 * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    int   low_cnt  = 0;
    logic [7:0] sb_q[$];

    player_data_tx_if #(.DATA_WIDTH(DW)) bus_if ();

    player_data_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .HEADER_BYTE (8'hA5)
    ) dut (
        .clk_pixel_in(clk),
        .rst_n_in    (rst_n),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_pkt(input logic [15:0] d, input logic [7:0] cs);
        sb_q.push_back(8'hA5);
        sb_q.push_back(d[15:8]);
        sb_q.push_back(d[7:0]);
        if (CSUM_EN) sb_q.push_back(cs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic strobe(input logic [15:0] d, output int c_edge);
        bus_if.data_in       = d;
        bus_if.data_in_valid = 1'b1;
        tick();
        c_edge = cyc;
        bus_if.data_in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (bus_if.packet_done_out === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no packet_done_out within %0d cycles", name, limit);
        end
    endtask

    // Line decoder: start edge, then mid-bit samples every CPB cycles.
    initial begin
        bit         m_act;
        int         m_cnt;
        logic [7:0] m_byte;
        m_act  = 1'b0;
        m_cnt  = 0;
        m_byte = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_act = 1'b0;
            end else begin
                if (bus_if.busy_out === 1'b1) busy_cnt++;
                if (bus_if.packet_done_out === 1'b1) done_cnt++;
                if (bus_if.tx_out !== 1'b1) low_cnt++;
                if (!m_act) begin
                    if (bus_if.tx_out === 1'b0) begin
                        m_act = 1'b1;
                        m_cnt = 0;
                    end
                end else begin
                    m_cnt++;
                    if ((m_cnt % CPB) == CPB / 2 && m_cnt > CPB && m_cnt < 9 * CPB) begin
                        m_byte[(m_cnt - CPB) / CPB] = bus_if.tx_out;
                    end
                    if (m_cnt == 9 * CPB + CPB / 2) begin
                        check("stop_bit", 32'(bus_if.tx_out), 32'd1);
                        if (sb_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL tx_byte: got %0h expected none (cycle %0d)", m_byte, cyc);
                        end else begin
                            check("tx_byte", 32'(m_byte), 32'(sb_q.pop_front()));
                        end
                        m_act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] data;
        logic [7:0]  csum;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   c0;
        int   cd;
        int   at;

        vecs[0] = '{16'h1234, 8'h26};
        vecs[1] = '{16'hA5A5, 8'h00};
        vecs[2] = '{16'h00FF, 8'hFF};
        vecs[3] = '{16'hBEEF, 8'h51};
        vecs[4] = '{16'h8001, 8'h81};
        vecs[5] = '{16'hFFFF, 8'h00};

        // Reset values, and a strobe held across reset release must be ignored.
        bus_if.data_in       = 16'h1234;
        bus_if.data_in_valid = 1'b1;
        repeat (3) tick();
        check("rst_tx", 32'(bus_if.tx_out), 32'd1);
        check("rst_busy", 32'(bus_if.busy_out), 32'd0);
        check("rst_done", 32'(bus_if.packet_done_out), 32'd0);
        rst_n = 1'b1;
        tick();
        bus_if.data_in_valid = 1'b0;
        repeat (60) tick();
        check("release_strobe_busy", 32'(busy_cnt), 32'd0);
        check("release_strobe_line", 32'(low_cnt), 32'd0);

        for (int i = 0; i < 6; i++) begin
            busy_cnt = 0;
            done_cnt = 0;
            push_pkt(vecs[i].data, vecs[i].csum);
            strobe(vecs[i].data, c0);
            check("latency_tx", 32'(bus_if.tx_out), 32'd0);
            check("latency_busy", 32'(bus_if.busy_out), 32'd1);
            wait_done("single_done", 2 * PKT_CYC, at);
            check("single_done_at", 32'(at - c0 + 1), 32'(PKT_CYC));
            tick();
            check("single_busy_len", 32'(busy_cnt), 32'(PKT_CYC));
            check("single_done_cnt", 32'(done_cnt), 32'd1);
            check("single_idle_tx", 32'(bus_if.tx_out), 32'd1);
            check("single_idle_busy", 32'(bus_if.busy_out), 32'd0);
            check("single_sb_empty", 32'(sb_q.size()), 32'd0);
            repeat (5) tick();
        end

        // Queued overwrite: only the newest pending word is sent, back-to-back.
        busy_cnt = 0;
        done_cnt = 0;
        push_pkt(16'h1234, 8'h26);
        strobe(16'h1234, c0);
        wait_until(c0 + 19);
        strobe(16'h0001, cd);
        wait_until(c0 + 49);
        push_pkt(16'hBEEF, 8'h51);
        strobe(16'hBEEF, cd);
        wait_done("queue_done1", 2 * PKT_CYC, at);
        check("queue_done1_at", 32'(at - c0 + 1), 32'(PKT_CYC));
        tick();
        check("queue_gapless_tx", 32'(bus_if.tx_out), 32'd0);
        check("queue_gapless_busy", 32'(bus_if.busy_out), 32'd1);
        wait_done("queue_done2", 2 * PKT_CYC, at);
        check("queue_done2_at", 32'(at - c0 + 1), 32'(2 * PKT_CYC));
        tick();
        check("queue_busy_len", 32'(busy_cnt), 32'(2 * PKT_CYC));
        check("queue_done_cnt", 32'(done_cnt), 32'd2);
        check("queue_idle_busy", 32'(bus_if.busy_out), 32'd0);
        check("queue_sb_empty", 32'(sb_q.size()), 32'd0);
        repeat (5) tick();

        // Strobe on the completion cycle wins over, and clears, the pending word.
        busy_cnt = 0;
        done_cnt = 0;
        push_pkt(16'h1234, 8'h26);
        strobe(16'h1234, c0);
        wait_until(c0 + 29);
        strobe(16'h0001, cd);
        wait_until(c0 + PKT_CYC - 1);
        check("simul_done_now", 32'(bus_if.packet_done_out), 32'd1);
        push_pkt(16'h00FF, 8'hFF);
        strobe(16'h00FF, cd);
        wait_done("simul_done2", 2 * PKT_CYC, at);
        check("simul_done2_at", 32'(at - c0 + 1), 32'(2 * PKT_CYC));
        repeat (PKT_CYC + 20) tick();
        check("simul_done_cnt", 32'(done_cnt), 32'd2);
        check("simul_idle_busy", 32'(bus_if.busy_out), 32'd0);
        check("simul_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset during the second payload byte aborts the packet for good.
        busy_cnt = 0;
        done_cnt = 0;
        sb_q.push_back(8'hA5);
        sb_q.push_back(8'h12);
        strobe(16'h1234, c0);
        wait_until(c0 + 95);
        rst_n = 1'b0;
        #1;
        check("abort_tx", 32'(bus_if.tx_out), 32'd1);
        check("abort_busy", 32'(bus_if.busy_out), 32'd0);
        check("abort_done", 32'(bus_if.packet_done_out), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        busy_cnt = 0;
        low_cnt  = 0;
        repeat (100) tick();
        check("abort_quiet_busy", 32'(busy_cnt), 32'd0);
        check("abort_quiet_line", 32'(low_cnt), 32'd0);
        check("abort_done_cnt", 32'(done_cnt), 32'd0);
        check("abort_sb_empty", 32'(sb_q.size()), 32'd0);

        done_cnt = 0;
        push_pkt(16'h00FF, 8'hFF);
        strobe(16'h00FF, c0);
        wait_done("after_abort_done", 2 * PKT_CYC, at);
        check("after_abort_done_at", 32'(at - c0 + 1), 32'(PKT_CYC));
        repeat (5) tick();
        check("after_abort_sb_empty", 32'(sb_q.size()), 32'd0);
        check("after_abort_done_cnt", 32'(done_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
